// File: rtl/key_register_mp_pkg.sv
// Shared types and helpers for the multi-port key register file.
package key_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_DONE  = 2'd2
  } scrub_state_e;

  localparam int unsigned MAX_PORTS = 4;

  // Low bit of port 'port' inside a flattened multi-port vector.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/key_register_mp_if.sv
// Write/read/scrub bus between the key-update logic, the lookup datapath and the key register file.
interface key_register_mp_if #(
  parameter int unsigned key_width   = 32,
  parameter int unsigned index_width = 8,
  parameter int unsigned num_wr      = 2,
  parameter int unsigned num_rd      = 2
) ();

  logic [num_wr-1:0]             w_en;
  logic [index_width*num_wr-1:0] w_addr;
  logic [key_width*num_wr-1:0]   key_in_write;
  logic [num_rd-1:0]             r_en;
  logic [index_width*num_rd-1:0] r_addr;
  logic [key_width*num_rd-1:0]   key_out_read;
  logic [num_rd-1:0]             r_valid;
  logic [num_rd-1:0]             r_hit;
  logic                          scrub_req;
  logic                          busy;
  logic [num_wr-1:0]             w_drop;

  modport master (
    output w_en, w_addr, key_in_write, r_en, r_addr, scrub_req,
    input  key_out_read, r_valid, r_hit, busy, w_drop
  );

  modport slave (
    input  w_en, w_addr, key_in_write, r_en, r_addr, scrub_req,
    output key_out_read, r_valid, r_hit, busy, w_drop
  );

endinterface

// File: rtl/key_register_mp_scrub_fsm.sv
// Scrub sequencer: walks every entry once, one per cycle, then holds busy for a final DONE cycle.
module key_reg_scrub_fsm
  import key_reg_pkg::*;
#(
  parameter int unsigned index_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scrub_req_i,
  output logic                   busy_o,
  output logic                   accept_c,
  output logic                   scrub_we_c,
  output logic [index_width-1:0] scrub_addr_o
);

  // One spare counter bit keeps the terminal compare from wrapping.
  localparam int unsigned CNT_W = index_width + 1;
  localparam int unsigned LAST  = (1 << index_width) - 1;

  scrub_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    accept_c   = 1'b0;
    scrub_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scrub_req_i) begin
          state_d  = ST_SCRUB;
          cnt_d    = '0;
          busy_d   = 1'b1;
          accept_c = 1'b1;
        end
      end
      ST_SCRUB: begin
        scrub_we_c = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o       = busy_q;
  assign scrub_addr_o = cnt_q[index_width-1:0];

endmodule

// File: rtl/key_register_mp.sv
// Multi-port key register file with per-entry valid bits, optional write bypass and a scrub engine.
module key_register_mp
  import key_reg_pkg::*;
#(
  parameter int unsigned key_width   = 32,
  parameter int unsigned index_width = 8,
  parameter int unsigned num_wr      = 2,
  parameter int unsigned num_rd      = 2,
  parameter int unsigned rd_latency  = 1,
  parameter int unsigned bypass      = 1
) (
  input logic              clk,
  input logic              reset,
  key_register_mp_if.slave bus
);

  localparam int unsigned DEPTH = 1 << index_width;
  localparam int unsigned NWR   = (num_wr < MAX_PORTS) ? num_wr : MAX_PORTS;
  localparam int unsigned NRD   = (num_rd < MAX_PORTS) ? num_rd : MAX_PORTS;

  logic [key_width-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]            valid_q;
  logic                        busy, accept_c, scrub_we_c;
  logic [index_width-1:0]      scrub_addr;
  logic [num_wr-1:0]           wr_ok_c;
  logic [key_width*num_rd-1:0] rd_data_c, key1_q;
  logic [num_rd-1:0]           rd_hit_c, hit1_q, rv1_q;

  key_reg_scrub_fsm #(.index_width(index_width)) u_scrub (
    .clk         (clk),
    .reset       (reset),
    .scrub_req_i (bus.scrub_req),
    .busy_o      (busy),
    .accept_c    (accept_c),
    .scrub_we_c  (scrub_we_c),
    .scrub_addr_o(scrub_addr)
  );

  // User writes are shut out while scrubbing, including the cycle the scrub is accepted.
  always_comb begin
    wr_ok_c    = '0;
    bus.w_drop = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_ok_c[i]    = bus.w_en[i] & ~busy & ~accept_c & ~reset;
      bus.w_drop[i] = bus.w_en[i] & (busy | accept_c) & ~reset;
    end
  end

  // Ascending port loop: the highest-indexed colliding writer lands last and wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (scrub_we_c) mem_q[scrub_addr] <= '0;
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok_c[i]) begin
          mem_q[bus.w_addr[slice_lo(i, index_width) +: index_width]] <=
            bus.key_in_write[slice_lo(i, key_width) +: key_width];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || accept_c) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok_c[i]) valid_q[bus.w_addr[slice_lo(i, index_width) +: index_width]] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [index_width-1:0] ra;
    ra        = '0;
    rd_data_c = '0;
    rd_hit_c  = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = bus.r_addr[slice_lo(j, index_width) +: index_width];
      rd_data_c[slice_lo(j, key_width) +: key_width] = mem_q[ra];
      rd_hit_c[j] = valid_q[ra];
      if (bypass != 0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_ok_c[i] && (bus.w_addr[slice_lo(i, index_width) +: index_width] == ra)) begin
            rd_data_c[slice_lo(j, key_width) +: key_width] =
              bus.key_in_write[slice_lo(i, key_width) +: key_width];
            rd_hit_c[j] = 1'b1;
          end
        end
      end
    end
  end

  // First read stage; idle ports keep their last result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rv1_q  <= '0;
      hit1_q <= '0;
      key1_q <= '0;
    end else begin
      rv1_q <= bus.r_en;
      for (int j = 0; j < NRD; j++) begin
        if (bus.r_en[j]) begin
          key1_q[slice_lo(j, key_width) +: key_width] <= rd_data_c[slice_lo(j, key_width) +: key_width];
          hit1_q[j] <= rd_hit_c[j];
        end
      end
    end
  end

  if (rd_latency == 2) begin : g_lat2
    logic [key_width*num_rd-1:0] key2_q;
    logic [num_rd-1:0]           hit2_q, rv2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rv2_q  <= '0;
        hit2_q <= '0;
        key2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        for (int j = 0; j < NRD; j++) begin
          if (rv1_q[j]) begin
            key2_q[slice_lo(j, key_width) +: key_width] <= key1_q[slice_lo(j, key_width) +: key_width];
            hit2_q[j] <= hit1_q[j];
          end
        end
      end
    end

    assign bus.key_out_read = key2_q;
    assign bus.r_hit        = hit2_q;
    assign bus.r_valid      = rv2_q;
  end else begin : g_lat1
    assign bus.key_out_read = key1_q;
    assign bus.r_hit        = hit1_q;
    assign bus.r_valid      = rv1_q;
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_key_register_mp.sv
// Bench: two instances (latency 1 with bypass, latency 2 without) share stimulus and are checked against a history-based model.
module tb_key_register_mp;

  localparam int KW = 32, IW = 8, NW = 2, NR = 2;
  localparam int DEPTH = 256, BUSY_LEN = 257, MAXC = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_register_mp_if #(.key_width(KW), .index_width(IW), .num_wr(NW), .num_rd(NR)) ifa ();
  key_register_mp_if #(.key_width(KW), .index_width(IW), .num_wr(NW), .num_rd(NR)) ifb ();

  assign ifb.w_en         = ifa.w_en;
  assign ifb.w_addr       = ifa.w_addr;
  assign ifb.key_in_write = ifa.key_in_write;
  assign ifb.r_en         = ifa.r_en;
  assign ifb.r_addr       = ifa.r_addr;
  assign ifb.scrub_req    = ifa.scrub_req;

  key_register_mp #(.key_width(KW), .index_width(IW), .num_wr(NW), .num_rd(NR),
                    .rd_latency(1), .bypass(1)) dut_a (.clk(clk), .reset(rst), .bus(ifa.slave));
  key_register_mp #(.key_width(KW), .index_width(IW), .num_wr(NW), .num_rd(NR),
                    .rd_latency(2), .bypass(0)) dut_b (.clk(clk), .reset(rst), .bus(ifb.slave));

  // Staged inputs, applied at the falling edge.
  logic [NW-1:0] s_w_en;
  logic [IW-1:0] s_wa [NW];
  logic [KW-1:0] s_wd [NW];
  logic [NR-1:0] s_r_en;
  logic [IW-1:0] s_ra [NR];
  logic          s_scrub, s_rst;

  // Model: array contents, valid bits, scrub start cycle, and per-cycle read history.
  logic [KW-1:0] m_mem [DEPTH];
  bit            m_valid [DEPTH];
  int            scrub_acc;
  bit            h_rst [MAXC];
  bit            h_iss [MAXC][NR];
  logic [KW-1:0] h_da [MAXC][NR], h_db [MAXC][NR];
  bit            h_ha [MAXC][NR], h_hb [MAXC][NR];
  logic [KW-1:0] held_a [NR], held_b [NR];
  bit            held_ha [NR], held_hb [NR];

  int t, n_chk, n_pass, cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%h required=%h", name, t, act, exp);
  endtask

  function automatic bit busy_at(input int c);
    return (scrub_acc >= 0) && (c > scrub_acc) && (c <= scrub_acc + BUSY_LEN);
  endfunction

  function automatic bit exp_rv(input int c, input int lat, input int j);
    if (c < lat) return 1'b0;
    if (!h_iss[c-lat][j]) return 1'b0;
    for (int k = c - lat; k < c; k++) if (h_rst[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_stage();
    s_w_en = '0; s_r_en = '0; s_scrub = 1'b0; s_rst = 1'b0;
    for (int i = 0; i < NW; i++) begin s_wa[i] = '0; s_wd[i] = '0; end
    for (int j = 0; j < NR; j++) s_ra[j] = '0;
  endtask

  task automatic check_outputs();
    logic [NR-1:0]    erv_a, erv_b, eh_a, eh_b;
    logic [NR*KW-1:0] ek_a, ek_b;
    for (int j = 0; j < NR; j++) begin
      if (h_rst[t-1]) begin
        held_a[j] = '0; held_ha[j] = 1'b0; held_b[j] = '0; held_hb[j] = 1'b0;
      end
      erv_a[j] = exp_rv(t, 1, j);
      erv_b[j] = exp_rv(t, 2, j);
      if (erv_a[j]) begin held_a[j] = h_da[t-1][j]; held_ha[j] = h_ha[t-1][j]; end
      if (erv_b[j]) begin held_b[j] = h_db[t-2][j]; held_hb[j] = h_hb[t-2][j]; end
      ek_a[j*KW +: KW] = held_a[j]; eh_a[j] = held_ha[j];
      ek_b[j*KW +: KW] = held_b[j]; eh_b[j] = held_hb[j];
    end
    chk("a_r_valid", ifa.r_valid, erv_a);
    chk("a_key", ifa.key_out_read, ek_a);
    chk("a_r_hit", ifa.r_hit, eh_a);
    chk("a_busy", ifa.busy, busy_at(t));
    chk("b_r_valid", ifb.r_valid, erv_b);
    chk("b_key", ifb.key_out_read, ek_b);
    chk("b_r_hit", ifb.r_hit, eh_b);
    chk("b_busy", ifb.busy, busy_at(t));
  endtask

  task automatic model_cycle();
    bit            bsy, acc;
    bit [NW-1:0]   wok;
    logic [NW-1:0] ed;
    int            off;
    bsy = busy_at(t);
    acc = !s_rst && !bsy && s_scrub;
    for (int i = 0; i < NW; i++) wok[i] = s_w_en[i] && !s_rst && !bsy && !acc;
    ed = (!s_rst && (bsy || acc)) ? s_w_en : '0;
    chk("a_w_drop", ifa.w_drop, ed);
    chk("b_w_drop", ifb.w_drop, ed);
    h_rst[t] = s_rst;
    for (int j = 0; j < NR; j++) begin
      h_iss[t][j] = s_r_en[j] && !s_rst;
      h_db[t][j]  = m_mem[s_ra[j]];
      h_hb[t][j]  = m_valid[s_ra[j]];
      h_da[t][j]  = h_db[t][j];
      h_ha[t][j]  = h_hb[t][j];
      for (int i = 0; i < NW; i++) begin
        if (wok[i] && s_wa[i] == s_ra[j]) begin h_da[t][j] = s_wd[i]; h_ha[t][j] = 1'b1; end
      end
    end
    if (s_rst) begin
      for (int a = 0; a < DEPTH; a++) m_valid[a] = 1'b0;
      scrub_acc = -1;
    end else begin
      off = t - scrub_acc - 1;
      if (bsy && off < DEPTH) m_mem[off] = '0;
      if (acc) begin
        for (int a = 0; a < DEPTH; a++) m_valid[a] = 1'b0;
        scrub_acc = t;
      end
      for (int i = 0; i < NW; i++) begin
        if (wok[i]) begin m_mem[s_wa[i]] = s_wd[i]; m_valid[s_wa[i]] = 1'b1; end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (t >= 2) check_outputs();
    ifa.w_en = s_w_en; ifa.r_en = s_r_en; ifa.scrub_req = s_scrub; rst = s_rst;
    for (int i = 0; i < NW; i++) begin
      ifa.w_addr[i*IW +: IW] = s_wa[i]; ifa.key_in_write[i*KW +: KW] = s_wd[i];
    end
    for (int j = 0; j < NR; j++) ifa.r_addr[j*IW +: IW] = s_ra[j];
    #1;
    model_cycle();
    t++;
    if (t >= MAXC) begin
      $display("FAIL cycle_budget exceeded at cycle %0d", t);
      $fatal(1, "cycle budget");
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    t = 0; n_chk = 0; n_pass = 0; scrub_acc = -1;
    for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; m_valid[a] = 1'b0; end
    ifa.w_en = '0; ifa.w_addr = '0; ifa.key_in_write = '0;
    ifa.r_en = '0; ifa.r_addr = '0; ifa.scrub_req = 1'b0; rst = 1'b1;

    clear_stage(); s_rst = 1'b1; step(); step();
    clear_stage(); settle();
    chk("reset_busy", {ifa.busy, ifb.busy}, 2'b00);
    chk("reset_r_valid", {ifa.r_valid, ifb.r_valid}, 4'b0000);

    // Full scrub also brings the array to a known all-zero state.
    s_w_en = 2'b01; s_wa[0] = 8'h03; s_wd[0] = 32'h0000_1234; step(); clear_stage();
    s_scrub = 1'b1; s_w_en = 2'b10; s_wa[1] = 8'h07; s_wd[1] = 32'h77; step();
    chk("accept_w_drop", ifa.w_drop, 2'b10);
    clear_stage();
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      settle();
      if (!ifa.busy) break;
      cnt++;
      if (k == 100) begin s_w_en = 2'b01; s_wa[0] = 8'h09; s_wd[0] = 32'h99; end
      step();
      if (k == 100) chk("busy_w_drop", ifa.w_drop, 2'b01);
      clear_stage();
    end
    chk("scrub_busy_cycles", cnt, BUSY_LEN);
    s_r_en = 2'b01; s_ra[0] = 8'h03; step(); clear_stage(); settle();
    chk("scrubbed_data", ifa.key_out_read[31:0], 32'h0);
    chk("scrubbed_hit", ifa.r_hit[0], 1'b0);

    s_w_en = 2'b01; s_wa[0] = 8'h05; s_wd[0] = 32'hDEAD_BEEF; step(); clear_stage();
    s_r_en = 2'b10; s_ra[1] = 8'h05; step(); clear_stage(); settle();
    chk("rd1_data", ifa.key_out_read[63:32], 32'hDEAD_BEEF);
    chk("rd1_hit_valid", {ifa.r_hit[1], ifa.r_valid[1]}, 2'b11);

    s_w_en = 2'b11; s_wa[0] = 8'h10; s_wd[0] = 32'h1111; s_wa[1] = 8'h10; s_wd[1] = 32'h2222;
    step(); clear_stage();
    s_r_en = 2'b01; s_ra[0] = 8'h10; step(); clear_stage(); settle();
    chk("collision_data", ifa.key_out_read[31:0], 32'h2222);

    s_w_en = 2'b01; s_wa[0] = 8'h20; s_wd[0] = 32'hAAAA; s_r_en = 2'b01; s_ra[0] = 8'h20;
    step(); clear_stage(); settle();
    chk("bypass_data", ifa.key_out_read[31:0], 32'hAAAA);
    chk("bypass_hit", ifa.r_hit[0], 1'b1);
    step(); settle();
    chk("nobypass_data", ifb.key_out_read[31:0], 32'h0);
    chk("nobypass_hit_valid", {ifb.r_hit[0], ifb.r_valid[0]}, 2'b01);

    s_w_en = 2'b11; s_wa[0] = 8'h01; s_wd[0] = 32'h0101; s_wa[1] = 8'h02; s_wd[1] = 32'h0202;
    step(); clear_stage();
    s_r_en = 2'b01; s_ra[0] = 8'h01; step(); clear_stage();
    s_r_en = 2'b01; s_ra[0] = 8'h02; step(); clear_stage(); settle();
    chk("lat2_first", {ifb.r_valid[0], ifb.key_out_read[31:0]}, {1'b1, 32'h0101});
    step(); settle();
    chk("lat2_second", {ifb.r_valid[0], ifb.key_out_read[31:0]}, {1'b1, 32'h0202});

    // Reset lands while the scrub counter sits at 0x40.
    s_scrub = 1'b1; step(); clear_stage();
    repeat (64) step();
    s_rst = 1'b1; step(); clear_stage(); settle();
    chk("midreset_busy", {ifa.busy, ifb.busy}, 2'b00);
    chk("midreset_r_valid", {ifa.r_valid, ifb.r_valid}, 4'b0000);
    s_w_en = 2'b10; s_wa[1] = 8'h41; s_wd[1] = 32'h4141; step(); clear_stage();
    s_r_en = 2'b01; s_ra[0] = 8'h41; step(); clear_stage(); settle();
    chk("post_reset_rw", {ifa.r_hit[0], ifa.key_out_read[31:0]}, {1'b1, 32'h4141});

    for (int n = 0; n < 1500; n++) begin
      clear_stage();
      s_rst   = ($urandom_range(0, 299) == 0);
      s_scrub = ($urandom_range(0, 199) == 0);
      s_w_en  = NW'($urandom_range(0, 3));
      s_r_en  = NR'($urandom_range(0, 3));
      for (int i = 0; i < NW; i++) begin
        s_wa[i] = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, 255)) : IW'($urandom_range(0, 15));
        s_wd[i] = $urandom;
      end
      for (int j = 0; j < NR; j++) s_ra[j] = IW'($urandom_range(0, 15));
      step();
    end
    clear_stage();
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_register_mp.md
Name: key_register_mp

Overview:
Parametrised multi-port key register file, successor to the two-port key register. Supports a configurable number of write and read ports, per-entry valid bits, registered read latency of 1 or 2, and a deterministic write-collision policy. Provides optional write-to-read bypass and a sequential scrub engine that zeroes the array. Sits between the PE key-update logic and the key lookup datapath.

Parameters:
key_width, 32, bits per key entry
index_width, 8, address width; depth = 2**index_width
num_wr, 2, number of write ports (1..4)
num_rd, 2, number of read ports (1..4)
rd_latency, 1, read latency in cycles (1 or 2)
bypass, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the old value

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
w_en  in  num_wr  per-port write enable
w_addr  in  index_width*num_wr  port i address at [i*index_width +: index_width]
key_in_write  in  key_width*num_wr  port i data at [i*key_width +: key_width]
r_en  in  num_rd  per-port read enable
r_addr  in  index_width*num_rd  port j address at [j*index_width +: index_width]
key_out_read  out  key_width*num_rd  port j data at [j*key_width +: key_width]
r_valid  out  num_rd  pulses with key_out_read, rd_latency cycles after r_en
r_hit  out  num_rd  addressed entry was valid at read time (qualified by r_valid)
scrub_req  in  1  single-cycle request to invalidate and zero the array
busy  out  1  scrub in progress
w_drop  out  num_wr  write on port i was discarded (scrub active)

Behaviour:
- Reset (reset=1 at a clock edge): all valid bits cleared; r_valid, r_hit, key_out_read, busy and w_drop = 0; FSM = IDLE. Array data is not cleared by reset.
- Reset wins over every other input. Reset during SCRUB aborts the scrub and returns to IDLE.
- Write: when w_en[i] and not busy, entry w_addr[i] = key_in_write[i] and valid[w_addr[i]] = 1 at the edge.
- Write collision: several ports write the same address in one cycle -> the highest port index wins. Losing ports are not flagged.
- Read, rd_latency=1: r_en[j] at edge N -> key_out_read[j], r_hit[j] and r_valid[j]=1 during cycle N+1.
- Read, rd_latency=2: the same result appears one cycle later through an extra output register stage.
- Outputs of ports with r_valid=0 hold their previous value.
- Same-cycle read and write to one address:
  - bypass=1: read returns the winning write data and r_hit=1.
  - bypass=0: read returns the pre-write data and pre-write valid.
- Reads are legal during SCRUB and return the current array contents. r_hit=0 for every entry from the cycle after scrub_req is accepted.
- Scrub FSM:
  - IDLE: scrub_req=1 -> SCRUB; all valid bits cleared at that edge; counter=0; busy=1 from the next cycle.
  - SCRUB: one entry per cycle, entry[counter] = 0 and counter+1. When counter = 2**index_width-1 is written -> DONE.
  - DONE: one cycle with busy=1, then IDLE with busy=0. Scrub takes 2**index_width+1 busy cycles in total.
  - scrub_req while busy is ignored.
- Writes with busy=1 are discarded, and w_drop[i] pulses in the same cycle.
- Writes arriving in the same cycle as an accepted scrub_req are discarded and flagged.
- The address counter is index_width+1 bits wide so the terminal test cannot wrap.

Decomposition:
- Package key_reg_pkg: FSM state encoding (IDLE, SCRUB, DONE), the max-port constant (4), and a helper function for the port-slice offset.
- Sub-module key_reg_scrub_fsm: FSM, counter, busy and the scrub write address/enable. The top level muxes scrub writes ahead of user writes.

Test Plan:
- Write port0 addr 0x05 = 0xDEADBEEF, then read port1 addr 0x05 with rd_latency=1 -> next cycle key_out_read[1]=0xDEADBEEF, r_hit=1, r_valid=1.
- Ports 0 and 1 write addr 0x10 with 0x1111 and 0x2222 in the same cycle, then read -> 0x2222.
- bypass=1: write 0xAAAA and read addr 0x20 in the same cycle, where the old entry is invalid -> 0xAAAA, hit=1. Repeat with bypass=0 -> hit=0.
- Write addr 0x03, pulse scrub_req -> busy=1 for 257 cycles (index_width=8). Write during busy -> w_drop pulses. After done, read 0x03 -> data 0, hit=0.
- Assert reset mid-scrub (counter=0x40) -> next cycle busy=0, all r_valid=0. A following write/read to 0x41 works normally.
- rd_latency=2: back-to-back reads of 0x01 and 0x02 on port0 -> results on cycles N+2 and N+3 in order, with r_valid continuous.
